// File: rtl/grid_defs.sv
// Shared definitions for the grid store controller: FSM encoding,
// default geometry and the cell index helper.
package grid_defs;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCAN      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } state_e;

  localparam int GRID_W_DEF  = 12;
  localparam int GRID_H_DEF  = 12;
  localparam int COORD_W_DEF = 8;

  // Flat bit position of cell (x, y); row 0 is the top row.
  function automatic int cell_idx(input int x, input int y, input int grid_w);
    return y * grid_w + x;
  endfunction

endpackage

// File: rtl/grid_row_shift.sv
// Combinational row collapse: drops rows 0..ptr-1 down by one, reports whether
// the row at ptr is full and whether the row that would drop into it is full.
module grid_row_shift
  import grid_defs::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int PTR_W  = $clog2(GRID_H)
) (
  input  logic [GRID_W*GRID_H-1:0] grid_i,
  input  logic [PTR_W-1:0]         ptr_i,
  output logic [GRID_W*GRID_H-1:0] shifted_o,
  output logic                     row_full_o,
  output logic                     above_full_o
);

  always_comb begin
    shifted_o    = grid_i;
    row_full_o   = 1'b0;
    above_full_o = 1'b0;
    // Row 0 always lies at or above the pointer, so zeros always enter there.
    shifted_o[GRID_W-1:0] = '0;
    for (int y = 1; y < GRID_H; y++) begin
      if (y <= int'(ptr_i))
        shifted_o[y*GRID_W +: GRID_W] = grid_i[(y-1)*GRID_W +: GRID_W];
    end
    for (int y = 0; y < GRID_H; y++) begin
      if (y == int'(ptr_i))
        row_full_o = &grid_i[y*GRID_W +: GRID_W];
      if (y + 1 == int'(ptr_i))
        above_full_o = &grid_i[y*GRID_W +: GRID_W];
    end
  end

endmodule

// File: rtl/grid_store_ctrl.sv
// Playfield store: collapses full rows of a committed grid bottom-up, then
// publishes grid, cleared-row count and score on the next frame boundary.
module grid_store_ctrl
  import grid_defs::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int SCORE_W = 16,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     commit_valid,
  input  logic [GRID_W*GRID_H-1:0] commit_data,
  output logic                     commit_ready,
  input  logic                     draw_finish,
  input  logic [COORD_W-1:0]       read_x,
  input  logic [COORD_W-1:0]       read_y,
  output logic                     coord_value,
  output logic [GRID_W*GRID_H-1:0] grid_out,
  output logic [CNT_W-1:0]         lines_cleared,
  output logic                     swap_pulse,
  output logic [SCORE_W-1:0]       score,
  output logic                     busy
);

  localparam int N     = GRID_W * GRID_H;
  localparam int PTR_W = $clog2(GRID_H);
  localparam int IDX_W = $clog2(N);

  state_e             state_q, state_d;
  logic [N-1:0]       work_q, work_d, disp_q, disp_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, lines_q, lines_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               swap_q, swap_d, coord_q, coord_d;
  logic [N-1:0]       shifted;
  logic               row_full, above_full;
  logic [IDX_W-1:0]   rd_idx;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [CNT_W-1:0]   b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + (SCORE_W+1)'(b);
    return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  endfunction

  grid_row_shift #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .PTR_W (PTR_W)
  ) u_shift (
    .grid_i      (work_q),
    .ptr_i       (ptr_q),
    .shifted_o   (shifted),
    .row_full_o  (row_full),
    .above_full_o(above_full)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    disp_d  = disp_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    score_d = score_q;
    swap_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_valid) begin
          work_d  = commit_data;
          ptr_d   = PTR_W'(GRID_H - 1);
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (row_full)            state_d = ST_SHIFT;
        else if (ptr_q == '0)    state_d = ST_WAIT_SWAP;
        else                     ptr_d   = ptr_q - PTR_W'(1);
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q + CNT_W'(1);
        // The dropped-in row is judged here, so a non-full row costs no extra
        // SCAN visit and accept-to-publish stays GRID_H + cleared rows.
        if (above_full)          state_d = ST_SHIFT;
        else if (ptr_q == '0)    state_d = ST_WAIT_SWAP;
        else begin
          ptr_d   = ptr_q - PTR_W'(1);
          state_d = ST_SCAN;
        end
      end
      ST_WAIT_SWAP: begin
        if (draw_finish) begin
          disp_d  = work_q;
          lines_d = cnt_q;
          score_d = sat_add(score_q, cnt_q);
          swap_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port looks only at the published buffer, whatever the FSM is doing.
  always_comb begin
    rd_idx  = IDX_W'(cell_idx(int'(read_x), int'(read_y), GRID_W));
    coord_d = 1'b0;
    if (int'(read_x) < GRID_W && int'(read_y) < GRID_H)
      coord_d = disp_q[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      disp_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      score_q <= '0;
      swap_q  <= 1'b0;
      coord_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      disp_q  <= disp_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      score_q <= score_d;
      swap_q  <= swap_d;
      coord_q <= coord_d;
    end
  end

  assign commit_ready  = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign grid_out      = disp_q;
  assign lines_cleared = lines_q;
  assign score         = score_q;
  assign swap_pulse    = swap_q;
  assign coord_value   = coord_q;

endmodule
